psum_col_accumulator: RTL
=========================

# psum_col_accumulator

Column partial-sum accumulator sitting directly downstream of the fusion unit. It takes the registered packed product word the fusion unit forwards each cycle and splits it into 1, 2 or 4 independent fields according to the weight precision. Each field is accumulated over a programmed number of valid beats. The finished column sums are presented through a single-entry valid/ready output register, so the next accumulation can start while the previous result waits.

## Interface
- COL_WIDTH, 13, width of one packed field in the fusion unit output; must match the fusion unit.
- ACC_WIDTH, 24, width of each accumulator lane.
- CNT_WIDTH, 16, width of the beat counter and acc_len.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- start  in  1  pulse; latches weight_width and acc_len and begins a job (IDLE only).
- weight_width  in  4  precision code: 4'b1000 → 1 field; 4'b0100 → 2 fields; anything else → 4 fields.
- acc_len  in  CNT_WIDTH  number of beats to accumulate; 0 is illegal.
- psum_valid  in  1  psum_in carries a beat this cycle.
- psum_in  in  4*COL_WIDTH  packed products from the fusion unit's psum_fwd.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  4*ACC_WIDTH  lane i at [ACC_WIDTH*(i+1)-1:ACC_WIDTH*i]; unused lanes are 0.
- busy  out  1  state is not IDLE.
- overflow  out  1  sticky: a lane add carried out during the current job.
- drop_err  out  1  sticky until reset: a psum_valid beat was discarded.

## Operation
- FSM states:
  - IDLE: start with acc_len≠0 → ACCUM; clears the accumulators, the beat counter and overflow. start with acc_len=0 is ignored.
  - ACCUM: each psum_valid beat adds its fields into the lanes and increments the counter. On the beat where count==acc_len-1, the final sum is formed:
    - output register free, or freed this cycle by out_ready: load it, go to IDLE.
    - otherwise: hold the sum, go to WAIT_OUT.
  - WAIT_OUT: when out_ready is high, the held sum loads the output register the next cycle; go to IDLE.
- Field extraction:
  - 1-field mode: field0 = psum_in[4C-1:0].
  - 2-field mode: field0 = [2C-1:0], field1 = [4C-1:2C].
  - 4-field mode: fieldi = [C*(i+1)-1:C*i].
  - Fields are zero-extended, or truncated to their low ACC_WIDTH bits. All arithmetic is unsigned.
- Ignored inputs:
  - start in ACCUM or WAIT_OUT is ignored.
  - psum_valid in IDLE is ignored silently.
  - psum_valid in WAIT_OUT is discarded and sets drop_err.
  - psum_valid in the start cycle is not counted.
- Output handshake: out_valid stays high and out_data stays stable until a cycle with out_valid && out_ready.
- Simultaneous events: a handshake and a final beat in the same cycle load the new result with no bubble.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0, overflow=0, drop_err=0, state IDLE, accumulators 0.
- Reset mid-job discards all partial and held results.
- busy rises the cycle after start.
- Latency: final beat at edge t → out_valid high after edge t+1.
- Throughput: one beat per cycle, with no stalls while the output register is free.
- Minimum job: start at t, single beat at t+1, out_valid at t+2, next start accepted at t+2.

## Configuration
- PSUM_ACC_SAT_EN defined: each lane clamps to 2^ACC_WIDTH-1 on carry-out and stays there for the rest of the job.
- PSUM_ACC_SAT_EN undefined: lanes wrap modulo 2^ACC_WIDTH.
- overflow reports carry-out in both builds.

## Structure
- Package psum_acc_pkg holds:
  - the state enum (IDLE, ACCUM, WAIT_OUT);
  - weight_width codes WW_8=4'b1000 and WW_4=4'b0100;
  - a function mapping weight_width to a field count.
- Sub-module psum_lane_acc: one lane with adder, clear, and wrap/saturate plus carry flag; instantiated 4×.
- Top level holds the FSM, counter, field mux and output/hold registers.

## Test plan
- Defaults, weight_width=1000, acc_len=3, fields 100, 200, 300 → lane0=600, lanes1–3=0, out_valid one cycle after the third beat.
- weight_width=0100, acc_len=2, fields (5,7) twice → lane0=10, lane1=14, lanes2–3=0.
- weight_width=0010, acc_len=1, fields 1,2,3,4 → lanes 1,2,3,4; next start accepted the cycle out_valid rises.
- out_ready=0, two back-to-back jobs of len 2 → second enters WAIT_OUT; an extra beat sets drop_err; out_ready=1 delivers job1 then job2 in order.
- weight_width=1000, acc_len=2100, field 8191 each beat:
  - without macro → lane0=423884, overflow=1;
  - with PSUM_ACC_SAT_EN → 16777215, overflow=1.
- rst_n low one cycle after 2 of 4 beats → all outputs 0 and state IDLE; the following job of len 1 with field 9 → lane0=9.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the column partial-sum accumulator.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    localparam logic [3:0] WW_8 = 4'b1000;
    localparam logic [3:0] WW_4 = 4'b0100;

    // Number of independent fields packed into one fusion-unit word.
    function automatic logic [2:0] field_count(input logic [3:0] ww);
        case (ww)
            WW_8:    return 3'd1;
            WW_4:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/psum_lane_acc.sv
// One accumulator lane: unsigned add with clear, carry flag and wrap or clamp.
// Macro PSUM_ACC_SAT_EN selects clamping to all-ones on carry-out.
module psum_lane_acc #(
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [ACC_WIDTH-1:0] field,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] sum_c,
    output logic                 carry_c
);

    logic [ACC_WIDTH:0] raw_c;

    always_comb begin
        raw_c   = {1'b0, acc} + {1'b0, field};
        carry_c = raw_c[ACC_WIDTH];
`ifdef PSUM_ACC_SAT_EN
        // Once clamped, any further non-zero add carries again, so the lane stays pinned.
        sum_c   = carry_c ? '1 : raw_c[ACC_WIDTH-1:0];
`else
        sum_c   = raw_c[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/psum_col_accumulator.sv
// Column partial-sum accumulator: splits fusion-unit words into 1/2/4 lanes and sums them
// over acc_len beats into a single-entry valid/ready output. Lane clamping: PSUM_ACC_SAT_EN.
module psum_col_accumulator
    import psum_acc_pkg::*;
#(
    parameter int unsigned COL_WIDTH = 13,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             weight_width,
    input  logic [CNT_WIDTH-1:0]   acc_len,
    input  logic                   psum_valid,
    input  logic [4*COL_WIDTH-1:0] psum_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*ACC_WIDTH-1:0] out_data,
    output logic                   busy,
    output logic                   overflow,
    output logic                   drop_err
);

    localparam int unsigned PSUM_W = 4 * COL_WIDTH;
    localparam int unsigned OUT_W  = 4 * ACC_WIDTH;

    state_t               state, state_n;
    logic [2:0]           nf_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] cnt;

    logic clr_c, add_c, load_new_c, load_held_c, final_c;

    logic [ACC_WIDTH-1:0] lane_field_c [4];
    logic [ACC_WIDTH-1:0] lane_acc     [4];
    logic [ACC_WIDTH-1:0] lane_sum_c   [4];
    logic [3:0]           lane_carry_c;
    logic [OUT_W-1:0]     sum_packed_c;
    logic [OUT_W-1:0]     acc_packed_c;

    // Field mux driven by the precision latched at start.
    always_comb begin
        for (int i = 0; i < 4; i++) lane_field_c[i] = '0;
        case (nf_q)
            3'd1: lane_field_c[0] = ACC_WIDTH'(psum_in);
            3'd2: begin
                lane_field_c[0] = ACC_WIDTH'(psum_in[2*COL_WIDTH-1:0]);
                lane_field_c[1] = ACC_WIDTH'(psum_in[PSUM_W-1:2*COL_WIDTH]);
            end
            default: begin
                for (int i = 0; i < 4; i++)
                    lane_field_c[i] = ACC_WIDTH'(psum_in[COL_WIDTH*i +: COL_WIDTH]);
            end
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        psum_lane_acc #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr_c),
            .en      (add_c),
            .field   (lane_field_c[g]),
            .acc     (lane_acc[g]),
            .sum_c   (lane_sum_c[g]),
            .carry_c (lane_carry_c[g])
        );
        assign sum_packed_c[ACC_WIDTH*g +: ACC_WIDTH] = lane_sum_c[g];
        assign acc_packed_c[ACC_WIDTH*g +: ACC_WIDTH] = lane_acc[g];
    end

    assign final_c = (cnt == len_q - CNT_WIDTH'(1));

    // Next-state and control decode.
    always_comb begin
        state_n     = state;
        clr_c       = 1'b0;
        add_c       = 1'b0;
        load_new_c  = 1'b0;
        load_held_c = 1'b0;
        case (state)
            IDLE: begin
                if (start && (acc_len != '0)) begin
                    clr_c   = 1'b1;
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    add_c = 1'b1;
                    if (final_c) begin
                        if (!out_valid || out_ready) begin
                            load_new_c = 1'b1;
                            state_n    = IDLE;
                        end else begin
                            state_n = WAIT_OUT;
                        end
                    end
                end
            end
            WAIT_OUT: begin
                // Lanes themselves hold the finished sum until the output frees.
                if (out_ready) begin
                    load_held_c = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            nf_q      <= 3'd4;
            len_q     <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            drop_err  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);

            if (clr_c) begin
                nf_q     <= field_count(weight_width);
                len_q    <= acc_len;
                cnt      <= '0;
                overflow <= 1'b0;
            end else if (add_c) begin
                cnt <= cnt + CNT_WIDTH'(1);
                if (|lane_carry_c) overflow <= 1'b1;
            end

            if ((state == WAIT_OUT) && psum_valid) drop_err <= 1'b1;

            // Handshake retires the current word; a same-cycle load replaces it with no bubble.
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (load_new_c) begin
                out_valid <= 1'b1;
                out_data  <= sum_packed_c;
            end else if (load_held_c) begin
                out_valid <= 1'b1;
                out_data  <= acc_packed_c;
            end
        end
    end

endmodule
